// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb_if
//  Description : Bus bundle for regfile_sb: write port, two read ports,
//                scoreboard reserve/busy and sequential dump stream.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_sb_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
);
    logic             we;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;
    logic [AW-1:0]    ra1;
    logic [AW-1:0]    ra2;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             rsv_en;
    logic [AW-1:0]    rsv_a;
    logic             busy1;
    logic             busy2;
    logic             dump_start;
    logic             dump_busy;
    logic             dump_valid;
    logic [AW-1:0]    dump_idx;
    logic [WIDTH-1:0] dump_data;

    modport master (
        output we, wa, wd, ra1, ra2, rsv_en, rsv_a, dump_start,
        input  rd1, rd2, busy1, busy2, dump_busy, dump_valid, dump_idx, dump_data
    );

    modport slave (
        input  we, wa, wd, ra1, ra2, rsv_en, rsv_a, dump_start,
        output rd1, rd2, busy1, busy2, dump_busy, dump_valid, dump_idx, dump_data
    );
endinterface
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb
//  Description : Flop-based register file with two combinational read ports,
//                optional hardwired zero register, optional write-to-read
//                forwarding, a per-register pending scoreboard and a
//                sequential dump engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb #(
    parameter int WIDTH    = 8,
    parameter int AW       = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic          clk,
    input  logic          rst,
    regfile_sb_if.slave   bus
);

    localparam int            DEPTH      = 2 ** AW;
    localparam logic [AW-1:0] c_last_idx = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_DUMP = 1'b1
    } state_t;

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0] r_pend;
    logic [DEPTH-1:0] w_pend_next;
    state_t           r_state;
    state_t           w_state_next;
    logic [AW-1:0]    r_idx;
    logic [AW-1:0]    w_idx_next;

    logic             w_wr_eff;
    logic             w_rsv_eff;
    logic             w_rsv_hold;
    logic             w_fwd1;
    logic             w_fwd2;
    logic             w_dumping;

    // Stored value as seen by a non-forwarded read; register 0 reads as zero
    // when it is hardwired.
    function automatic logic [WIDTH-1:0] f_stored(input logic [AW-1:0] a);
        if ((ZERO_REG != 0) && (a == '0)) begin
            return '0;
        end
        return r_regs[a];
    endfunction

    // Writes and reserves aimed at a hardwired zero register are dropped.
    assign w_wr_eff   = bus.we && !((ZERO_REG != 0) && (bus.wa == '0));
    assign w_rsv_eff  = bus.rsv_en && !((ZERO_REG != 0) && (bus.rsv_a == '0));
    // A reserve landing on the register being written keeps it pending.
    assign w_rsv_hold = w_wr_eff && w_rsv_eff && (bus.rsv_a == bus.wa);

    assign w_fwd1 = (BYPASS != 0) && w_wr_eff && (bus.wa == bus.ra1);
    assign w_fwd2 = (BYPASS != 0) && w_wr_eff && (bus.wa == bus.ra2);

    // Register storage: cleared by reset, updated by an effective write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_eff) begin
            r_regs[bus.wa] <= bus.wd;
        end
    end

    // Scoreboard next value: write clears, reserve sets, reserve applied last
    // so it wins on a collision.
    always_comb begin
        w_pend_next = r_pend;
        if (w_wr_eff) begin
            w_pend_next[bus.wa] = 1'b0;
        end
        if (w_rsv_eff) begin
            w_pend_next[bus.rsv_a] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_next;
        end
    end

    // Read ports: forwarding has priority, otherwise storage (zero in reset).
    assign bus.rd1 = w_fwd1 ? bus.wd : (rst ? '0 : f_stored(bus.ra1));
    assign bus.rd2 = w_fwd2 ? bus.wd : (rst ? '0 : f_stored(bus.ra2));

    // Busy: pending bit, masked by a same-cycle forwarded write that is not
    // simultaneously re-reserved.
    assign bus.busy1 = !rst && r_pend[bus.ra1] && !(w_fwd1 && !w_rsv_hold);
    assign bus.busy2 = !rst && r_pend[bus.ra2] && !(w_fwd2 && !w_rsv_hold);

    // Dump FSM state and index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // Dump FSM next state, index and stream outputs.
    always_comb begin
        w_state_next   = r_state;
        w_idx_next     = r_idx;
        w_dumping      = (r_state == S_DUMP) && !rst;
        bus.dump_busy  = w_dumping;
        bus.dump_valid = w_dumping;
        bus.dump_idx   = '0;
        bus.dump_data  = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.dump_start) begin
                    w_state_next = S_DUMP;
                    w_idx_next   = '0;
                end
            end
            S_DUMP: begin
                if (r_idx == c_last_idx) begin
                    w_state_next = S_IDLE;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next = r_idx + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_idx_next   = '0;
            end
        endcase
        if (w_dumping) begin
            bus.dump_idx  = r_idx;
            bus.dump_data = f_stored(r_idx);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_sb
//  Description : Self-checking bench for regfile_sb. Two instances share one
//                stimulus stream: u_a (ZERO_REG=1, BYPASS=1) and
//                u_b (ZERO_REG=0, BYPASS=0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile_sb_if #(.WIDTH(8), .AW(3)) bus_a ();
    regfile_sb_if #(.WIDTH(8), .AW(3)) bus_b ();

    regfile_sb #(.WIDTH(8), .AW(3), .ZERO_REG(1), .BYPASS(1)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    regfile_sb #(.WIDTH(8), .AW(3), .ZERO_REG(0), .BYPASS(0)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    typedef struct {
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic [2:0] ra1;
        logic [2:0] ra2;
        logic       rsv;
        logic [2:0] rsv_a;
        logic [7:0] a_rd1;
        logic [7:0] a_rd2;
        logic       a_b1;
        logic       a_b2;
        logic [7:0] b_rd1;
        logic [7:0] b_rd2;
        logic       b_b1;
        logic       b_b2;
    } vec_t;

    typedef struct {
        logic [2:0] idx;
        logic [7:0] data;
    } dexp_t;

    vec_t  vecs [17];
    dexp_t q_a [$];
    dexp_t q_b [$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                         input logic [2:0] ra1, input logic [2:0] ra2,
                         input logic rsv, input logic [2:0] rsv_a, input logic ds);
        bus_a.we = we;   bus_a.wa = wa;   bus_a.wd = wd;
        bus_a.ra1 = ra1; bus_a.ra2 = ra2;
        bus_a.rsv_en = rsv; bus_a.rsv_a = rsv_a; bus_a.dump_start = ds;
        bus_b.we = we;   bus_b.wa = wa;   bus_b.wd = wd;
        bus_b.ra1 = ra1; bus_b.ra2 = ra2;
        bus_b.rsv_en = rsv; bus_b.rsv_a = rsv_a; bus_b.dump_start = ds;
    endtask

    // Dump stream monitor: expected valid whenever the scoreboard queue holds
    // entries; each valid cycle pops and compares one entry.
    task automatic mon_a(input string tag);
        dexp_t e;
        logic  exp_v;
        exp_v = (q_a.size() > 0);
        chk({tag, "_a_valid"}, bus_a.dump_valid, exp_v);
        chk({tag, "_a_busy"}, bus_a.dump_busy, exp_v);
        if (exp_v && bus_a.dump_valid) begin
            e = q_a.pop_front();
            chk({tag, "_a_idx"}, bus_a.dump_idx, e.idx);
            chk({tag, "_a_data"}, bus_a.dump_data, e.data);
        end else if (!exp_v) begin
            chk({tag, "_a_idle_idx"}, bus_a.dump_idx, 0);
            chk({tag, "_a_idle_data"}, bus_a.dump_data, 0);
        end
    endtask

    task automatic mon_b(input string tag);
        dexp_t e;
        logic  exp_v;
        exp_v = (q_b.size() > 0);
        chk({tag, "_b_valid"}, bus_b.dump_valid, exp_v);
        chk({tag, "_b_busy"}, bus_b.dump_busy, exp_v);
        if (exp_v && bus_b.dump_valid) begin
            e = q_b.pop_front();
            chk({tag, "_b_idx"}, bus_b.dump_idx, e.idx);
            chk({tag, "_b_data"}, bus_b.dump_data, e.data);
        end else if (!exp_v) begin
            chk({tag, "_b_idle_idx"}, bus_b.dump_idx, 0);
            chk({tag, "_b_idle_data"}, bus_b.dump_data, 0);
        end
    endtask

    task automatic push_dump(input logic [7:0] d6);
        dexp_t e;
        for (int k = 0; k < 8; k++) begin
            e.idx  = 3'(k);
            e.data = (k == 0) ? 8'h00 : ((k == 6) ? d6 : 8'(16 + k));
            q_a.push_back(e);
            q_b.push_back(e);
        end
    endtask

    initial begin
        //        we wa wd     ra1 ra2 rsv ra  | A: rd1  rd2  b1 b2 | B: rd1  rd2  b1 b2
        vecs[0]  = '{1, 3, 'hA5, 3, 0, 0, 0,  'hA5, 'h00, 0, 0,  'h00, 'h00, 0, 0};
        vecs[1]  = '{0, 0, 'h00, 3, 3, 0, 0,  'hA5, 'hA5, 0, 0,  'hA5, 'hA5, 0, 0};
        vecs[2]  = '{1, 0, 'hFF, 0, 3, 0, 0,  'h00, 'hA5, 0, 0,  'h00, 'hA5, 0, 0};
        vecs[3]  = '{0, 0, 'h00, 0, 0, 0, 0,  'h00, 'h00, 0, 0,  'hFF, 'hFF, 0, 0};
        vecs[4]  = '{1, 5, 'h3C, 3, 5, 0, 0,  'hA5, 'h3C, 0, 0,  'hA5, 'h00, 0, 0};
        vecs[5]  = '{0, 0, 'h00, 5, 5, 0, 0,  'h3C, 'h3C, 0, 0,  'h3C, 'h3C, 0, 0};
        vecs[6]  = '{0, 0, 'h00, 2, 2, 1, 2,  'h00, 'h00, 0, 0,  'h00, 'h00, 0, 0};
        vecs[7]  = '{0, 0, 'h00, 2, 5, 0, 0,  'h00, 'h3C, 1, 0,  'h00, 'h3C, 1, 0};
        vecs[8]  = '{1, 2, 'h77, 2, 2, 0, 0,  'h77, 'h77, 0, 0,  'h00, 'h00, 1, 1};
        vecs[9]  = '{0, 0, 'h00, 2, 2, 0, 0,  'h77, 'h77, 0, 0,  'h77, 'h77, 0, 0};
        vecs[10] = '{1, 6, 'h66, 6, 6, 1, 6,  'h66, 'h66, 0, 0,  'h00, 'h00, 0, 0};
        vecs[11] = '{0, 0, 'h00, 6, 2, 0, 0,  'h66, 'h77, 1, 0,  'h66, 'h77, 1, 0};
        vecs[12] = '{0, 0, 'h00, 0, 6, 1, 0,  'h00, 'h66, 0, 1,  'hFF, 'h66, 0, 1};
        vecs[13] = '{0, 0, 'h00, 0, 1, 0, 0,  'h00, 'h00, 0, 0,  'hFF, 'h00, 1, 0};
        vecs[14] = '{1, 6, 'h55, 6, 0, 1, 6,  'h55, 'h00, 1, 0,  'h66, 'hFF, 1, 1};
        vecs[15] = '{1, 6, 'h44, 6, 0, 0, 0,  'h44, 'h00, 0, 0,  'h55, 'hFF, 1, 1};
        vecs[16] = '{0, 0, 'h00, 6, 3, 0, 0,  'h44, 'hA5, 0, 0,  'h44, 'hA5, 0, 0};

        // Reset state, including overriding a simultaneous write/reserve/start.
        rst = 1'b1;
        drive(1, 5, 'h12, 7, 5, 1, 5, 1);
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("rst_a_rd1", bus_a.rd1, 'h00);
        chk("rst_a_rd2_fwd", bus_a.rd2, 'h12);
        chk("rst_b_rd2", bus_b.rd2, 'h00);
        chk("rst_a_busy2", bus_a.busy2, 0);
        chk("rst_a_dbusy", bus_a.dump_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 5, 7, 0, 0, 0);
        #2;
        chk("post_rst_a_rd1", bus_a.rd1, 'h00);
        chk("post_rst_b_rd1", bus_b.rd1, 'h00);
        chk("post_rst_a_busy1", bus_a.busy1, 0);
        mon_a("post_rst");

        // Table-driven functional vectors.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2,
                  vecs[i].rsv, vecs[i].rsv_a, 0);
            #2;
            chk($sformatf("v%0d_a_rd1", i), bus_a.rd1, vecs[i].a_rd1);
            chk($sformatf("v%0d_a_rd2", i), bus_a.rd2, vecs[i].a_rd2);
            chk($sformatf("v%0d_a_busy1", i), bus_a.busy1, vecs[i].a_b1);
            chk($sformatf("v%0d_a_busy2", i), bus_a.busy2, vecs[i].a_b2);
            chk($sformatf("v%0d_b_rd1", i), bus_b.rd1, vecs[i].b_rd1);
            chk($sformatf("v%0d_b_rd2", i), bus_b.rd2, vecs[i].b_rd2);
            chk($sformatf("v%0d_b_busy1", i), bus_b.busy1, vecs[i].b_b1);
            chk($sformatf("v%0d_b_busy2", i), bus_b.busy2, vecs[i].b_b2);
            chk($sformatf("v%0d_a_dvalid", i), bus_a.dump_valid, 0);
        end

        // Clean slate, then preload regfile[k] = 0x10 + k.
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k < 8; k++) begin
            drive(1, 3'(k), 8'(16 + k), 0, 0, 0, 0, 0);
            @(negedge clk);
        end

        // Full dump: second start in dump cycle 3 ignored, reg 6 written in
        // dump cycle 2 shows the new value when reached.
        for (int c = 0; c < 14; c++) begin
            if (c != 0) @(negedge clk);
            drive((c == 3), 6, 'h99, 0, 0, 0, 0, (c == 0) || (c == 4));
            #2;
            mon_a($sformatf("dump_c%0d", c));
            mon_b($sformatf("dump_c%0d", c));
            if (c == 0) push_dump('h99);
        end
        chk("dump_a_left", q_a.size(), 0);
        chk("dump_b_left", q_b.size(), 0);

        // Mid-dump reset in dump cycle 4.
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            rst = (c == 5);
            if (c == 5) begin
                q_a.delete();
                q_b.delete();
                drive(1, 3, 'h5A, 1, 3, 0, 0, 0);
            end else begin
                drive(0, 0, 0, 1, 3, (c == 1), 1, (c == 0));
            end
            #2;
            mon_a($sformatf("rstdump_c%0d", c));
            mon_b($sformatf("rstdump_c%0d", c));
            if (c >= 2 && c <= 4) begin
                chk($sformatf("rstdump_c%0d_a_busy1", c), bus_a.busy1, 1);
                chk($sformatf("rstdump_c%0d_b_busy1", c), bus_b.busy1, 1);
            end
            if (c == 5) begin
                chk("rstdump_in_a_rd1", bus_a.rd1, 'h00);
                chk("rstdump_in_a_rd2", bus_a.rd2, 'h5A);
                chk("rstdump_in_b_rd2", bus_b.rd2, 'h00);
                chk("rstdump_in_a_busy1", bus_a.busy1, 0);
                chk("rstdump_in_b_busy1", bus_b.busy1, 0);
            end
            if (c >= 6) begin
                chk($sformatf("rstdump_c%0d_a_rd1", c), bus_a.rd1, 'h00);
                chk($sformatf("rstdump_c%0d_a_rd2", c), bus_a.rd2, 'h00);
                chk($sformatf("rstdump_c%0d_b_rd1", c), bus_b.rd1, 'h00);
                chk($sformatf("rstdump_c%0d_b_rd2", c), bus_b.rd2, 'h00);
                chk($sformatf("rstdump_c%0d_a_busy1", c), bus_a.busy1, 0);
                chk($sformatf("rstdump_c%0d_b_busy1", c), bus_b.busy1, 0);
                chk($sformatf("rstdump_c%0d_a_busy2", c), bus_a.busy2, 0);
            end
            if (c == 0) push_dump('h99);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter WIDTH, default 8, data width of each register.
REQ-002 Parameter AW, default 3, address width; DEPTH = 2**AW registers.
REQ-003 Parameter ZERO_REG, default 1. When 1, register 0 is hardwired to zero.
REQ-004 Parameter BYPASS, default 1. When 1, write-to-read forwarding in the same cycle is enabled.
REQ-005 Port list:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  write enable.
- wa  in  AW  write address.
- wd  in  WIDTH  write data.
- ra1, ra2  in  AW each  read addresses.
- rd1, rd2  out  WIDTH each  read data.
- rsv_en  in  1  reserve (mark pending) request.
- rsv_a  in  AW  register to reserve.
- busy1, busy2  out  1 each  pending status of ra1 / ra2.
- dump_start  in  1  request sequential dump of all registers.
- dump_busy  out  1  dump in progress.
- dump_valid  out  1  dump_idx/dump_data are valid.
- dump_idx  out  AW  index of the register being dumped.
- dump_data  out  WIDTH  contents of that register.

Function
REQ-006 A write is "effective" when we=1 and not (ZERO_REG=1 and wa=0). An effective write updates regfile[wa] with wd at the rising edge.
REQ-007 Reads are combinational: rd1=regfile[ra1] and rd2=regfile[ra2]. When ZERO_REG=1, a read of address 0 returns 0.
REQ-008 When BYPASS=1, an effective write with wa==raN drives rdN=wd in the same cycle. When BYPASS=0, rdN shows the old value until the edge.
REQ-009 The scoreboard holds one pend bit per register. rsv_en=1 sets pend[rsv_a] at the edge.
REQ-010 An effective write clears pend[wa] at the edge.
REQ-011 If an effective write and a reserve target the same address in the same cycle, pend stays 1 (reserve wins).
REQ-012 When ZERO_REG=1, a reserve of register 0 is ignored and pend[0] is always 0.
REQ-013 Base value busyN = pend[raN].
REQ-014 When BYPASS=1, busyN is forced to 0 for an effective write with wa==raN, unless the conditions of REQ-011 hold for that address.
REQ-015 The dump FSM has states IDLE and DUMP, with an AW-bit index counter idx.
REQ-016 In IDLE, dump_start=1 moves the FSM to DUMP at the edge with idx=0. Otherwise it stays in IDLE.
REQ-017 In DUMP, each cycle drives:
- dump_valid=1
- dump_idx=idx
- dump_data = the value a read of idx would return with BYPASS=0 (the value before this cycle's write).
REQ-018 In DUMP, idx increments each edge. At idx=DEPTH-1 the FSM returns to IDLE and idx wraps to 0, so each dump lasts exactly DEPTH cycles.
REQ-019 dump_start is ignored while in DUMP; there is no restart or queueing.
REQ-020 Writes and reserves proceed normally during a dump. A register written before its index is reached shows the new value.
REQ-021 dump_busy=1 exactly when the state is DUMP. In IDLE, dump_valid=0, dump_idx=0 and dump_data=0.
REQ-022 All storage is flops (no RAM inference requirement). The design has no combinational loop between the inputs and busyN/rdN other than the documented bypass paths.

Reset
REQ-023 rst=1 at a rising edge clears all regfile entries and all pend bits, sets the state to IDLE and idx to 0.
REQ-024 Reset overrides a simultaneous we, rsv_en or dump_start.
REQ-025 While rst=1:
- rd1, rd2 show 0, except that under BYPASS=1 an effective write (REQ-006) still forwards wd per REQ-008.
- dump_busy=0 and dump_valid=0.
- busyN follows REQ-013/REQ-014, so it reads 0.
REQ-026 Reset asserted mid-dump aborts the dump. The next cycle is IDLE with dump_valid=0.

Verification (WIDTH=8, AW=3 unless stated)
REQ-027 Write and read-back: we=1, wa=3, wd=0xA5; next cycle ra1=3 -> rd1=0xA5.
REQ-028 Zero-register writes:
- With ZERO_REG=1: we=1, wa=0, wd=0xFF; ra1=0 -> rd1=0.
- With ZERO_REG=0, the same stimulus gives rd1=0xFF.
REQ-029 Bypass: ra2=5 while we=1, wa=5, wd=0x3C:
- With BYPASS=1 -> rd2=0x3C in the same cycle.
- With BYPASS=0 -> rd2=old value, then 0x3C next cycle.
REQ-030 Scoreboard:
- rsv_en=1, rsv_a=2 -> busy1(ra1=2)=1 the next cycle.
- Then a write of wa=2 -> busy1=0 in the same cycle (BYPASS=1) and 0 afterwards.
- A simultaneous reserve and write of address 6 -> busy stays 1.
REQ-031 Dump: preload regfile[k]=0x10+k for k=1..7, then pulse dump_start.
- dump_valid is high for exactly 8 cycles with idx 0..7 and data 0x00, 0x11 .. 0x17.
- A second dump_start pulse in cycle 3 is ignored.
- A write of reg 6 to 0x99 in dump cycle 2 shows dump_data=0x99 at idx 6.
REQ-032 Mid-dump reset: rst=1 during dump cycle 4 -> next cycle:
- dump_busy=0
- all rd outputs 0
- all busy outputs 0
